// File: rtl/activation_pwl_pipe.sv
// activation_pwl_pipe: multi-lane 3-stage piecewise-linear sigmoid/tanh/relu/bypass unit with saturation counter
module activation_pwl_pipe #(
  parameter int INT_BIT = 7,
  parameter int FRAC_BIT = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16,
  localparam int IW = INT_BIT + FRAC_BIT + 1,
  localparam int OW = FRAC_BIT + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IW-1:0]   in_data,
  input  logic [1:0]            in_mode,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*OW-1:0]   out_data,
  output logic                  out_last,
  input  logic                  sat_clr,
  output logic [CNT_W-1:0]      sat_cnt
);
  localparam int TW = IW + 2;
  localparam int YW = FRAC_BIT + 1;
  localparam logic [TW-1:0] T1 = TW'(1) << FRAC_BIT;
  localparam logic [TW-1:0] T2 = T1 << 1;
  localparam logic [TW-1:0] T4 = T1 << 2;
  localparam logic [TW-1:0] T8 = T1 << 3;
  localparam logic [YW-1:0] Y_HALF = YW'(1) << (FRAC_BIT - 1);
  localparam logic [YW-1:0] Y_5_8 = YW'(5) << (FRAC_BIT - 3);
  localparam logic [YW-1:0] Y_13_16 = YW'(13) << (FRAC_BIT - 4);
  localparam logic [YW-1:0] Y_7_8 = YW'(7) << (FRAC_BIT - 3);
  localparam logic [YW-1:0] Y_ONE = YW'(1) << FRAC_BIT;
  localparam logic [OW-1:0] O_ONE = OW'(1) << FRAC_BIT;
  localparam logic [OW-1:0] O_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] O_MIN = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [IW-1:0] PMAX = IW'(2 ** (OW - 1) - 1);
  localparam logic signed [IW-1:0] NMIN = IW'(-(2 ** (OW - 1)));

  logic v1, v2, v3, ld1, ld2, ld3;
  logic [1:0] m1, m2;
  logic l1, l2, l3, s3_sat;
  logic [LANES-1:0] lane_sat;

  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready = ld1 && !rst;
  assign out_valid = v3;
  assign out_last = l3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1) begin
      m1 <= in_mode;
      l1 <= in_last;
    end
    if (ld2) begin
      m2 <= m1;
      l2 <= l1;
    end
    if (ld3) begin
      l3 <= l2;
      s3_sat <= |lane_sat;
    end
  end

  // clear wins over a same-cycle increment; count sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || sat_clr) sat_cnt <= '0;
    else if (out_valid && out_ready && s3_sat && !(&sat_cnt)) sat_cnt <= sat_cnt + CNT_W'(1);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IW-1:0] x0, x1, x2;
    logic [IW:0] a0;
    logic [TW-1:0] t0, t1;
    logic [2:0] sg0, sg1;
    logic n1, n2, top2, hi, lo;
    logic [YW-1:0] y1, y2;
    logic [OW-1:0] yo, sg_o, th_s, th_o, re_o, by_o, o, o3;
    assign x0 = in_data[k*IW +: IW];
    // one extra bit so the most-negative input does not wrap
    assign a0 = x0[IW-1] ? -{x0[IW-1], x0} : {1'b0, x0};
    assign t0 = in_mode == 2'd1 ? {a0, 1'b0} : {1'b0, a0};
    assign sg0 = t0 <= T1 ? 3'd0 : t0 <= T2 ? 3'd1 : t0 <= T4 ? 3'd2 : t0 <= T8 ? 3'd3 : 3'd4;
    assign y1 = sg1 == 3'd0 ? Y_HALF + YW'(t1 >> 2) :
                sg1 == 3'd1 ? Y_5_8 + YW'(t1 >> 3) :
                sg1 == 3'd2 ? Y_13_16 + YW'(t1 >> 5) :
                sg1 == 3'd3 ? Y_7_8 + YW'(t1 >> 6) : Y_ONE;
    assign yo = {1'b0, y2};
    assign sg_o = n2 ? O_ONE - yo : yo;
    assign th_s = (yo << 1) - O_ONE;
    assign th_o = n2 ? -th_s : th_s;
    assign hi = $signed(x2) > PMAX;
    assign lo = $signed(x2) < NMIN;
    assign re_o = n2 ? '0 : hi ? O_MAX : x2[OW-1:0];
    assign by_o = hi ? O_MAX : lo ? O_MIN : x2[OW-1:0];
    assign o = m2 == 2'd0 ? sg_o : m2 == 2'd1 ? th_o : m2 == 2'd2 ? re_o : by_o;
    assign lane_sat[k] = m2[1] ? (hi || (m2[0] && lo)) : top2;
    assign out_data[k*OW +: OW] = o3;
    always_ff @(posedge clk) begin
      if (ld1) begin
        x1 <= x0;
        t1 <= t0;
        sg1 <= sg0;
        n1 <= x0[IW-1];
      end
      if (ld2) begin
        x2 <= x1;
        y2 <= y1;
        n2 <= n1;
        top2 <= sg1 == 3'd4;
      end
      if (ld3) o3 <= o;
    end
  end
endmodule

// File: tb/tb_activation_pwl_pipe.sv
// tb_activation_pwl_pipe: directed self-checking bench for the PWL activation pipeline
module tb_activation_pwl_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, sat_clr = 1'b0;
  logic [1:0] in_mode = 2'd0;
  logic [63:0] in_data = '0;
  logic ready_set = 1'b1, rnd_en = 1'b0, rnd_bit = 1'b0;
  logic out_ready;
  logic in_ready, out_valid, out_last, in_ready2, out_valid2, out_last2;
  logic [39:0] out_data, out_data2;
  logic [15:0] sat_cnt;
  logic [2:0] sat_cnt2;
  int compared = 0, mismatched = 0;
  logic [39:0] got_d[$];
  logic got_l[$];

  assign out_ready = rnd_en ? rnd_bit : ready_set;

  activation_pwl_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  activation_pwl_pipe #(.CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_last(out_last2), .sat_clr(sat_clr), .sat_cnt(sat_cnt2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    #4;
    if (!rst && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
  end

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [39:0] po(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [63:0] stim(input int i);
    logic [63:0] d;
    for (int l = 0; l < 4; l++) d[l*16 +: 16] = 16'(i * 23 + l * 50 - 200);
    return d;
  endfunction

  function automatic logic [39:0] expo(input int i);
    logic [39:0] d;
    int v;
    for (int l = 0; l < 4; l++) begin
      v = i * 23 + l * 50 - 200;
      if (i % 2 == 1 && v < 0) v = 0;
      d[l*10 +: 10] = 10'(v);
    end
    return d;
  endfunction

  task automatic send(input logic [1:0] m, input logic [63:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d; in_last = l;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL send: in_ready stuck low for %0d cycles, required 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (got_d.size() < n && c < 100) begin
      @(negedge clk); c++;
    end
    if (got_d.size() < n) begin
      compared++; mismatched++;
      $display("FAIL wait_out: got %0d beats, required %0d", got_d.size(), n);
    end
  endtask

  task automatic measure_latency(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 10) begin
      @(negedge clk); cycles++;
    end
  endtask

  task automatic fill(input int v, output int acc);
    acc = 0;
    @(negedge clk);
    while (acc < 10) begin
      in_valid = 1'b1; in_mode = 2'd3; in_data = pk(v + acc, v + acc, v + acc, v + acc); in_last = 1'b0;
      #1;
      if (!in_ready) break;
      acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    compared++; if (in_ready2 !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready2: got %b, required 0", in_ready2); end
    compared++; if (sat_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_sat_cnt: got %0d, required 0", sat_cnt); end
    rst = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_sigmoid;
    got_d.delete(); got_l.delete();
    send(2'd0, pk(0, 256, -256, 768), 1'b1);
    wait_out(1);
    compared++; if (got_d[0] !== po(128, 192, 64, 232)) begin mismatched++; $display("FAIL sigmoid_basic: got %h, required %h", got_d[0], po(128, 192, 64, 232)); end
    compared++; if (got_l[0] !== 1'b1) begin mismatched++; $display("FAIL sigmoid_last: got %b, required 1", got_l[0]); end
    compared++; if (sat_cnt !== 16'd0) begin mismatched++; $display("FAIL sigmoid_nosat: got %0d, required 0", sat_cnt); end
    send(2'd0, pk(2048, 2049, 0, 0), 1'b0);
    wait_out(2);
    compared++; if (got_d[1] !== po(256, 256, 128, 128)) begin mismatched++; $display("FAIL sigmoid_edge: got %h, required %h", got_d[1], po(256, 256, 128, 128)); end
    compared++; if (got_l[1] !== 1'b0) begin mismatched++; $display("FAIL sigmoid_last0: got %b, required 0", got_l[1]); end
    compared++; if (sat_cnt !== 16'd1) begin mismatched++; $display("FAIL sigmoid_sat: got %0d, required 1", sat_cnt); end
  endtask

  task automatic test_tanh;
    got_d.delete(); got_l.delete();
    send(2'd1, pk(0, 256, -256, 1280), 1'b0);
    send(2'd1, pk(0, 0, 0, -32768), 1'b1);
    wait_out(2);
    compared++; if (got_d[0] !== po(0, 192, 'h340, 256)) begin mismatched++; $display("FAIL tanh_basic: got %h, required %h", got_d[0], po(0, 192, 'h340, 256)); end
    compared++; if (got_d[1] !== po(0, 0, 0, 'h300)) begin mismatched++; $display("FAIL tanh_minneg: got %h, required %h", got_d[1], po(0, 0, 0, 'h300)); end
    compared++; if (sat_cnt !== 16'd3) begin mismatched++; $display("FAIL tanh_sat: got %0d, required 3", sat_cnt); end
  endtask

  task automatic test_relu_bypass;
    got_d.delete(); got_l.delete();
    send(2'd2, pk(-256, 384, 768, 0), 1'b0);
    send(2'd3, pk(-256, 600, -600, 100), 1'b1);
    wait_out(2);
    compared++; if (got_d[0] !== po(0, 384, 511, 0)) begin mismatched++; $display("FAIL relu: got %h, required %h", got_d[0], po(0, 384, 511, 0)); end
    compared++; if (got_d[1] !== po('h300, 511, 'h200, 100)) begin mismatched++; $display("FAIL bypass: got %h, required %h", got_d[1], po('h300, 511, 'h200, 100)); end
    compared++; if (sat_cnt !== 16'd5) begin mismatched++; $display("FAIL relu_bypass_sat: got %0d, required 5", sat_cnt); end
    compared++; if (sat_cnt2 !== 3'd5) begin mismatched++; $display("FAIL relu_bypass_sat2: got %0d, required 5", sat_cnt2); end
  endtask

  task automatic test_latency;
    int cyc;
    got_d.delete(); got_l.delete();
    send(2'd0, pk(0, 0, 0, 0), 1'b0);
    measure_latency(cyc);
    compared++; if (cyc !== 3) begin mismatched++; $display("FAIL latency: got %0d, required 3", cyc); end
    wait_out(1);
    compared++; if (got_d[0] !== po(128, 128, 128, 128)) begin mismatched++; $display("FAIL latency_data: got %h, required %h", got_d[0], po(128, 128, 128, 128)); end
  endtask

  task automatic test_back_pressure;
    int acc;
    got_d.delete(); got_l.delete();
    ready_set = 1'b0;
    fill(1, acc);
    compared++; if (acc !== 3) begin mismatched++; $display("FAIL bp_fill: got %0d, required 3", acc); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
    repeat (2) @(negedge clk);
    compared++; if (out_data !== po(1, 1, 1, 1)) begin mismatched++; $display("FAIL bp_hold: got %h, required %h", out_data, po(1, 1, 1, 1)); end
    ready_set = 1'b1;
    wait_out(3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      compared++; if (got_d[i] !== po(i + 1, i + 1, i + 1, i + 1)) begin mismatched++; $display("FAIL bp_order%0d: got %h, required %h", i, got_d[i], po(i + 1, i + 1, i + 1, i + 1)); end
    end
  endtask

  task automatic test_stream;
    int i = 0, guard = 0;
    got_d.delete(); got_l.delete();
    rnd_en = 1'b1;
    while (i < 20 && guard < 400) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = (i % 2 == 1) ? 2'd2 : 2'd3; in_data = stim(i); in_last = (i % 3 == 0);
      #1;
      if (in_ready) i++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (i < 20) begin compared++; mismatched++; $display("FAIL stream_send: sent %0d beats, required 20", i); end
    wait_out(20);
    rnd_en = 1'b0; ready_set = 1'b1;
    repeat (4) @(negedge clk);
    compared++; if (got_d.size() !== 20) begin mismatched++; $display("FAIL stream_count: got %0d, required 20", got_d.size()); end
    for (int j = 0; j < 20 && j < got_d.size(); j++) begin
      compared++; if (got_d[j] !== expo(j) || got_l[j] !== (j % 3 == 0)) begin mismatched++; $display("FAIL stream_beat%0d: got %h/%b, required %h/%b", j, got_d[j], got_l[j], expo(j), j % 3 == 0); end
    end
  endtask

  task automatic test_sat_clr;
    int c = 0;
    got_d.delete(); got_l.delete();
    ready_set = 1'b0;
    send(2'd2, pk(768, 0, 0, 0), 1'b1);
    while (!out_valid && c < 10) begin @(negedge clk); c++; end
    compared++; if (out_data !== po(511, 0, 0, 0)) begin mismatched++; $display("FAIL clr_data: got %h, required %h", out_data, po(511, 0, 0, 0)); end
    compared++; if (out_data2 !== po(511, 0, 0, 0) || out_last2 !== 1'b1 || out_valid2 !== 1'b1) begin mismatched++; $display("FAIL clr_dut2: got %h/%b/%b, required %h/1/1", out_data2, out_last2, out_valid2, po(511, 0, 0, 0)); end
    ready_set = 1'b1; sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    compared++; if (sat_cnt !== 16'd0) begin mismatched++; $display("FAIL clr_priority: got %0d, required 0", sat_cnt); end
    compared++; if (sat_cnt2 !== 3'd0) begin mismatched++; $display("FAIL clr_priority2: got %0d, required 0", sat_cnt2); end
    compared++; if (got_d.size() !== 1) begin mismatched++; $display("FAIL clr_accept: got %0d, required 1", got_d.size()); end
  endtask

  task automatic test_stick;
    for (int i = 0; i < 9; i++) send(2'd2, pk(768, 0, 0, 0), 1'b0);
    wait_out(10);
    compared++; if (sat_cnt !== 16'd9) begin mismatched++; $display("FAIL stick_count: got %0d, required 9", sat_cnt); end
    compared++; if (sat_cnt2 !== 3'd7) begin mismatched++; $display("FAIL stick_max: got %0d, required 7", sat_cnt2); end
  endtask

  task automatic test_rst_mid;
    int acc, cyc;
    ready_set = 1'b0;
    fill(7, acc);
    compared++; if (acc !== 3 || out_valid !== 1'b1) begin mismatched++; $display("FAIL rst_fill: got %0d/%b, required 3/1", acc, out_valid); end
    rst = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    compared++; if (sat_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_sat_cnt: got %0d, required 0", sat_cnt); end
    rst = 1'b0;
    ready_set = 1'b1;
    got_d.delete(); got_l.delete();
    send(2'd3, pk(5, 6, 7, 8), 1'b1);
    measure_latency(cyc);
    compared++; if (cyc !== 3) begin mismatched++; $display("FAIL rst_latency: got %0d, required 3", cyc); end
    wait_out(1);
    repeat (5) @(negedge clk);
    compared++; if (got_d.size() !== 1) begin mismatched++; $display("FAIL rst_discard: got %0d beats, required 1", got_d.size()); end
    compared++; if (got_d[0] !== po(5, 6, 7, 8) || got_l[0] !== 1'b1) begin mismatched++; $display("FAIL rst_beat: got %h/%b, required %h/1", got_d[0], got_l[0], po(5, 6, 7, 8)); end
  endtask

  initial begin
    test_reset();
    test_sigmoid();
    test_tanh();
    test_relu_bypass();
    test_latency();
    test_back_pressure();
    test_stream();
    test_sat_clr();
    test_stick();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
